tcu_priv_formsg_gen: RTL and testbench
======================================

Name: tcu_priv_formsg_gen

Overview:
Upstream feeder of the privileged core-request unit. It watches message-arrival events from the receive path and detects foreign messages, i.e. messages for a VPE other than the one currently running. It buffers these as deduplicated foreign-message requests and pushes them into the core-request unit's push/data/stall port. Pushes are rate-limited so that unit's one-cycle-late full flag can never overflow.

Parameters:
TCU_EP_SIZE, 16, endpoint id width
TCU_VPEID_SIZE, 16, VPE id width
TCU_VPEID_INVALID, 16'hFFFF, VPE id marking "no owner"; such arrivals are never foreign
PEND_DEPTH, 4, pending-request buffer entries (power of 2, >=2)
PEND_AW, 2, log2(PEND_DEPTH)

Ports:
clk_i  in  1  clock
reset_i  in  1  reset (one clock; reset is synchronous and active-high)
msg_arrive_valid_i  in  1  message stored into a receive EP this cycle
msg_arrive_ready_o  out  1  block can accept an arrival event
msg_arrive_ep_i  in  TCU_EP_SIZE  receiving EP id
msg_arrive_vpeid_i  in  TCU_VPEID_SIZE  VPE owning that EP
cur_vpeid_i  in  TCU_VPEID_SIZE  VPE currently running on the core
core_req_formsg_push_o  out  1  one-cycle push of a foreign-msg request
core_req_formsg_data_o  out  TCU_VPEID_SIZE+TCU_EP_SIZE  {vpeid, ep}; ep in LSBs
core_req_formsg_stall_i  in  1  downstream buffer full
formsg_pending_o  out  PEND_AW+1  buffered entry count
formsg_dup_cnt_o  out  16  saturating count of suppressed duplicate arrivals

Behaviour:
- Reset (reset_i=1 at posedge): buffer emptied, rd/wr pointers 0, FSM to S_IDLE, dup counter 0. In any cycle with state S_IDLE and empty buffer: push_o=0, data_o=0, ready_o=1, pending_o=0. Reset mid-operation discards all pending entries; push_o is 0 in the cycle following reset.
- ready_o = (count < PEND_DEPTH). It is combinational from registered count and does not depend on a same-cycle pop.
- Arrival accepted on valid_i && ready_o. Classification of an accepted arrival:
  - vpeid == cur_vpeid_i or vpeid == TCU_VPEID_INVALID: ignored.
  - {vpeid, ep} equal to any valid entry (pre-pop contents, head included): dropped; dup counter +1, saturating at 16'hFFFF.
  - Otherwise: written at wr_ptr on the clock edge; wr_ptr wraps modulo PEND_DEPTH.
- count updates: +1 on store, -1 on pop, unchanged if both happen in the same cycle.
- FSM (3 states):
  - S_IDLE:
    - Empty: stay.
    - Head vpeid == cur_vpeid_i: pop (discard), stay; the VPE is now running, so no request is needed.
    - Otherwise: go to S_PUSH.
  - S_PUSH:
    - Head vpeid == cur_vpeid_i: pop without push, go to S_IDLE.
    - Else if !stall_i: push_o=1, data_o={head.vpeid, head.ep}, pop, go to S_GAP.
    - Else: stay; push_o=0, data_o still shows head.
  - S_GAP: push_o=0, unconditionally go to S_IDLE. This guarantees at least two idle cycles between pushes and covers the downstream registered-push/full lag.
- push_o is asserted only in S_PUSH with stall_i low, and never in two consecutive cycles.
- data_o = head entry in S_PUSH; 0 otherwise.
- Latency: arrival accepted at edge N. S_PUSH is entered at edge N+1, so push_o is high in cycle N+1 (0-stall case). Peak throughput is 1 request per 3 cycles.
- Order is FIFO; discards never reorder the remaining entries.

Test Plan:
1. cur_vpeid=5; arrival ep=3, vpeid=7 -> push_o high exactly one cycle, 2 cycles after the valid cycle, data_o={16'h0007, 16'h0003}; pending 1->0.
2. cur_vpeid=5; arrivals vpeid=5, then vpeid=16'hFFFF -> no push, pending stays 0, dup_cnt 0.
3. stall_i=1 held; arrivals (ep1,vpe7), (ep1,vpe7), (ep2,vpe7) -> pending=2, dup_cnt=1; release stall -> two pushes, ep1 then ep2, separated by >=2 low cycles.
4. stall_i=1; 4 distinct foreign arrivals -> pending=4, ready_o=0, 5th valid not accepted; release stall -> 4 pushes in order; pointers wrap; 5th retried and pushed last.
5. stall_i=1 with entry (ep4,vpe9) pending; set cur_vpeid=9 -> entry discarded without push, pending 0.
6. Assert reset_i for 1 cycle with 3 pending while in S_PUSH -> push_o=0, pending=0, ready_o=1, no later pushes.

Source files
------------

// File: rtl/tcu_priv_formsg_gen.sv
// tcu_priv_formsg_gen: detects message arrivals for a non-running VPE, keeps
// them as deduplicated foreign-message requests in a small FIFO, and feeds
// them to the core-request unit at most once every three cycles.
module tcu_priv_formsg_gen #(
   parameter int unsigned                TCU_EP_SIZE       = 16,
   parameter int unsigned                TCU_VPEID_SIZE    = 16,
   parameter logic [TCU_VPEID_SIZE-1:0]  TCU_VPEID_INVALID = 16'hFFFF,
   parameter int unsigned                PEND_DEPTH        = 4,
   parameter int unsigned                PEND_AW           = 2
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic                                  msg_arrive_valid_i,
   output logic                                  msg_arrive_ready_o,
   input  logic [TCU_EP_SIZE-1:0]                msg_arrive_ep_i,
   input  logic [TCU_VPEID_SIZE-1:0]             msg_arrive_vpeid_i,
   input  logic [TCU_VPEID_SIZE-1:0]             cur_vpeid_i,
   output logic                                  core_req_formsg_push_o,
   output logic [TCU_VPEID_SIZE+TCU_EP_SIZE-1:0] core_req_formsg_data_o,
   input  logic                                  core_req_formsg_stall_i,
   output logic [PEND_AW:0]                      formsg_pending_o,
   output logic [15:0]                           formsg_dup_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PUSH = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   localparam logic [PEND_AW:0] DEPTH_C = (PEND_AW+1)'(PEND_DEPTH);

   logic [TCU_EP_SIZE-1:0]    ep_q  [PEND_DEPTH];
   logic [TCU_VPEID_SIZE-1:0] vpe_q [PEND_DEPTH];
   logic [PEND_DEPTH-1:0]     vld_q;
   logic [PEND_AW-1:0]        rd_ptr_q, wr_ptr_q;
   logic [PEND_AW:0]          count_q;
   logic [15:0]               dup_cnt_q;
   state_t                    state_q, state_d;

   logic                      accept, is_local, dup_hit, store, dup;
   logic                      empty, head_local, pop, push;
   logic [TCU_EP_SIZE-1:0]    head_ep;
   logic [TCU_VPEID_SIZE-1:0] head_vpe;
   logic [TCU_VPEID_SIZE+TCU_EP_SIZE-1:0] data;

   assign msg_arrive_ready_o     = (count_q < DEPTH_C);
   assign formsg_pending_o       = count_q;
   assign formsg_dup_cnt_o       = dup_cnt_q;
   assign core_req_formsg_push_o = push;
   assign core_req_formsg_data_o = data;

   // Classify an arrival: local/unowned, duplicate of any buffered entry, or new.
   always_comb begin
      accept   = msg_arrive_valid_i && msg_arrive_ready_o;
      is_local = (msg_arrive_vpeid_i == cur_vpeid_i) ||
                 (msg_arrive_vpeid_i == TCU_VPEID_INVALID);
      dup_hit  = 1'b0;
      for (int unsigned i = 0; i < PEND_DEPTH; i++) begin
         if (vld_q[PEND_AW'(i)] &&
             (ep_q[PEND_AW'(i)]  == msg_arrive_ep_i) &&
             (vpe_q[PEND_AW'(i)] == msg_arrive_vpeid_i)) begin
            dup_hit = 1'b1;
         end
      end
      store      = accept && !is_local && !dup_hit;
      dup        = accept && !is_local &&  dup_hit;
      empty      = (count_q == '0);
      head_ep    = ep_q[rd_ptr_q];
      head_vpe   = vpe_q[rd_ptr_q];
      head_local = (head_vpe == cur_vpeid_i);
   end

   // Push FSM: next state, pop strobe and push/data outputs.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      push    = 1'b0;
      data    = '0;
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               if (head_local) pop = 1'b1;
               else            state_d = S_PUSH;
            end
         end
         S_PUSH: begin
            data = {head_vpe, head_ep};
            if (head_local) begin
               pop     = 1'b1;
               state_d = S_IDLE;
            end else if (!core_req_formsg_stall_i) begin
               push    = 1'b1;
               pop     = 1'b1;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control state: FSM, pointers, occupancy, valid flags, duplicate counter.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         vld_q     <= '0;
         dup_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (pop) begin
            vld_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q        <= rd_ptr_q + PEND_AW'(1);
         end
         // Store and pop never hit the same slot: pop needs a non-empty
         // buffer and store needs a non-full one, so the pointers differ.
         if (store) begin
            vld_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q        <= wr_ptr_q + PEND_AW'(1);
         end
         case ({store, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (dup && (dup_cnt_q != '1)) begin
            dup_cnt_q <= dup_cnt_q + 16'd1;
         end
      end
   end

   // Entry payload storage; validity is tracked separately in vld_q.
   always_ff @(posedge clk_i) begin
      if (store) begin
         ep_q[wr_ptr_q]  <= msg_arrive_ep_i;
         vpe_q[wr_ptr_q] <= msg_arrive_vpeid_i;
      end
   end

endmodule

// File: tb/tb_tcu_priv_formsg_gen.sv
// Self-checking bench for tcu_priv_formsg_gen: expected pushes are queued as
// arrivals are driven and matched against push_o/data_o by a monitor.
module tb_tcu_priv_formsg_gen;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        msg_arrive_valid_i;
   logic        msg_arrive_ready_o;
   logic [15:0] msg_arrive_ep_i;
   logic [15:0] msg_arrive_vpeid_i;
   logic [15:0] cur_vpeid_i;
   logic        core_req_formsg_push_o;
   logic [31:0] core_req_formsg_data_o;
   logic        core_req_formsg_stall_i;
   logic [2:0]  formsg_pending_o;
   logic [15:0] formsg_dup_cnt_o;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];

   tcu_priv_formsg_gen #(
      .TCU_EP_SIZE(16),
      .TCU_VPEID_SIZE(16),
      .TCU_VPEID_INVALID(16'hFFFF),
      .PEND_DEPTH(4),
      .PEND_AW(2)
   ) dut (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .msg_arrive_valid_i(msg_arrive_valid_i),
      .msg_arrive_ready_o(msg_arrive_ready_o),
      .msg_arrive_ep_i(msg_arrive_ep_i),
      .msg_arrive_vpeid_i(msg_arrive_vpeid_i),
      .cur_vpeid_i(cur_vpeid_i),
      .core_req_formsg_push_o(core_req_formsg_push_o),
      .core_req_formsg_data_o(core_req_formsg_data_o),
      .core_req_formsg_stall_i(core_req_formsg_stall_i),
      .formsg_pending_o(formsg_pending_o),
      .formsg_dup_cnt_o(formsg_dup_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: every push must match the scoreboard head and be >=3 cycles apart.
   int cyc = 0;
   int last_push = -100;
   always @(negedge clk_i) begin
      cyc++;
      if (core_req_formsg_push_o === 1'b1) begin
         chk("push_gap_ok", ((cyc - last_push) >= 3) ? 64'd1 : 64'd0, 64'd1);
         last_push = cyc;
         if (exp_q.size() == 0) begin
            chk("unexpected_push", {32'd0, core_req_formsg_data_o}, 64'hDEAD);
         end else begin
            chk("push_data", {32'd0, core_req_formsg_data_o}, {32'd0, exp_q[0]});
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Drive one arrival, holding valid until accepted (bounded).
   task automatic arrive(input logic [15:0] ep, input logic [15:0] vpe, input bit exp_push);
      bit ok;
      ok = 1'b0;
      msg_arrive_valid_i = 1'b1;
      msg_arrive_ep_i    = ep;
      msg_arrive_vpeid_i = vpe;
      for (int i = 0; i < 64; i++) begin
         if (msg_arrive_ready_o) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok) begin
         if (exp_push) exp_q.push_back({vpe, ep});
         tick();
      end else begin
         chk("arrive_accept_timeout", 64'd0, 64'd1);
      end
      msg_arrive_valid_i = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() == 0 && formsg_pending_o == 3'd0) break;
         tick();
      end
      tick(); tick(); tick();
      chk({name, "_sb_empty"}, exp_q.size(), 0);
      chk({name, "_pending0"}, formsg_pending_o, 0);
   endtask

   typedef struct {
      logic [15:0] cur;
      logic [15:0] ep;
      logic [15:0] vpe;
      bit          push;
   } vec_t;

   vec_t vecs [7];

   initial begin
      vecs[0] = '{cur: 16'h0005, ep: 16'h0003, vpe: 16'h0007, push: 1'b1};
      vecs[1] = '{cur: 16'h0005, ep: 16'h0009, vpe: 16'h0005, push: 1'b0};
      vecs[2] = '{cur: 16'h0005, ep: 16'h0009, vpe: 16'hFFFF, push: 1'b0};
      vecs[3] = '{cur: 16'h0000, ep: 16'h0000, vpe: 16'h0001, push: 1'b1};
      vecs[4] = '{cur: 16'h1234, ep: 16'hFFFF, vpe: 16'hFFFE, push: 1'b1};
      vecs[5] = '{cur: 16'hFFFF, ep: 16'h0042, vpe: 16'hFFFF, push: 1'b0};
      vecs[6] = '{cur: 16'h0007, ep: 16'h0003, vpe: 16'h0007, push: 1'b0};

      reset_i                 = 1'b1;
      msg_arrive_valid_i      = 1'b0;
      msg_arrive_ep_i         = '0;
      msg_arrive_vpeid_i      = '0;
      cur_vpeid_i             = 16'd5;
      core_req_formsg_stall_i = 1'b0;
      tick(); tick();
      reset_i = 1'b0;
      chk("rst_push", core_req_formsg_push_o, 0);
      chk("rst_data", core_req_formsg_data_o, 0);
      chk("rst_ready", msg_arrive_ready_o, 1);
      chk("rst_pending", formsg_pending_o, 0);
      chk("rst_dup", formsg_dup_cnt_o, 0);

      // Exact latency: accepted at edge N, push high in the cycle after N+1.
      cur_vpeid_i = 16'd5;
      arrive(16'd3, 16'd7, 1'b1);
      chk("t1_pending1", formsg_pending_o, 1);
      chk("t1_push_n", core_req_formsg_push_o, 0);
      tick();
      chk("t1_push_n1", core_req_formsg_push_o, 1);
      chk("t1_data", core_req_formsg_data_o, 32'h0007_0003);
      tick();
      chk("t1_push_n2", core_req_formsg_push_o, 0);
      chk("t1_pending0", formsg_pending_o, 0);
      wait_drain("t1");

      // Table of single arrivals under various current VPEs.
      for (int i = 0; i < 7; i++) begin
         cur_vpeid_i = vecs[i].cur;
         arrive(vecs[i].ep, vecs[i].vpe, vecs[i].push);
         chk($sformatf("vec%0d_pending", i), formsg_pending_o, vecs[i].push ? 1 : 0);
         wait_drain($sformatf("vec%0d", i));
      end
      chk("t2_dup0", formsg_dup_cnt_o, 0);

      // Duplicate suppression under stall.
      cur_vpeid_i = 16'd5;
      core_req_formsg_stall_i = 1'b1;
      arrive(16'd1, 16'd7, 1'b1);
      arrive(16'd1, 16'd7, 1'b0);
      arrive(16'd2, 16'd7, 1'b1);
      chk("t3_pending2", formsg_pending_o, 2);
      chk("t3_dup1", formsg_dup_cnt_o, 1);
      chk("t3_no_push_stall", core_req_formsg_push_o, 0);
      core_req_formsg_stall_i = 1'b0;
      wait_drain("t3");

      // Fill to capacity, then a fifth arrival waits for space.
      core_req_formsg_stall_i = 1'b1;
      for (int i = 0; i < 4; i++) arrive(16'(10 + i), 16'd8, 1'b1);
      chk("t4_pending4", formsg_pending_o, 4);
      chk("t4_ready0", msg_arrive_ready_o, 0);
      msg_arrive_valid_i = 1'b1;
      msg_arrive_ep_i    = 16'd14;
      msg_arrive_vpeid_i = 16'd8;
      tick(); tick(); tick();
      chk("t4_still4", formsg_pending_o, 4);
      core_req_formsg_stall_i = 1'b0;
      arrive(16'd14, 16'd8, 1'b1);
      wait_drain("t4");

      // Pending entry becomes local when its VPE starts running.
      core_req_formsg_stall_i = 1'b1;
      cur_vpeid_i = 16'd5;
      arrive(16'd4, 16'd9, 1'b0);
      tick();
      chk("t5_pending1", formsg_pending_o, 1);
      cur_vpeid_i = 16'd9;
      tick(); tick();
      chk("t5_pending0", formsg_pending_o, 0);
      core_req_formsg_stall_i = 1'b0;
      tick(); tick(); tick(); tick();
      chk("t5_sb_empty", exp_q.size(), 0);

      // Reset mid-operation with three stalled entries.
      cur_vpeid_i = 16'd5;
      core_req_formsg_stall_i = 1'b1;
      arrive(16'd20, 16'd6, 1'b0);
      arrive(16'd21, 16'd6, 1'b0);
      arrive(16'd22, 16'd6, 1'b0);
      tick();
      chk("t6_pending3", formsg_pending_o, 3);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      chk("t6_push0", core_req_formsg_push_o, 0);
      chk("t6_pending0", formsg_pending_o, 0);
      chk("t6_ready1", msg_arrive_ready_o, 1);
      chk("t6_dup0", formsg_dup_cnt_o, 0);
      core_req_formsg_stall_i = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("t6_sb_empty", exp_q.size(), 0);
      chk("t6_pending_end", formsg_pending_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule
